mem_rd_arbiter: RTL and testbench

MEM_RD_ARBITER -- requirements
Module: mem_rd_arbiter

---
 rtl/mem_rd_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_rd_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rd_arbiter.sv
// Two-requester AXI read arbiter in front of one memory read port.
// One burst in flight at a time, round-robin on ties, sticky burst-length error flag.
module mem_rd_arbiter #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 512,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              CLK,
  input  logic              ARESETN,

  input  logic [ADDR_W-1:0] S0_AXI_araddr,
  input  logic [LEN_W-1:0]  S0_AXI_arlen,
  input  logic              S0_AXI_arvalid,
  output logic              S0_AXI_arready,
  output logic [DATA_W-1:0] S0_AXI_rdata,
  output logic [1:0]        S0_AXI_rresp,
  output logic              S0_AXI_rlast,
  output logic              S0_AXI_rvalid,
  input  logic              S0_AXI_rready,

  input  logic [ADDR_W-1:0] S1_AXI_araddr,
  input  logic [LEN_W-1:0]  S1_AXI_arlen,
  input  logic              S1_AXI_arvalid,
  output logic              S1_AXI_arready,
  output logic [DATA_W-1:0] S1_AXI_rdata,
  output logic [1:0]        S1_AXI_rresp,
  output logic              S1_AXI_rlast,
  output logic              S1_AXI_rvalid,
  input  logic              S1_AXI_rready,

  output logic [ADDR_W-1:0] M_AXI_MEM_araddr,
  output logic [LEN_W-1:0]  M_AXI_MEM_arlen,
  output logic              M_AXI_MEM_arvalid,
  input  logic              M_AXI_MEM_arready,
  input  logic [DATA_W-1:0] M_AXI_MEM_rdata,
  input  logic [1:0]        M_AXI_MEM_rresp,
  input  logic              M_AXI_MEM_rlast,
  input  logic              M_AXI_MEM_rvalid,
  output logic              M_AXI_MEM_rready,

  output logic              grant_id,
  output logic              busy,
  output logic              len_err
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  localparam logic [LEN_W:0] CntOne = {{LEN_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_id_q, grant_id_d;
  logic [LEN_W:0]    beat_cnt_q, beat_cnt_d;
  logic              len_err_q, len_err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;

  logic           pick;
  logic           in_idle, in_data;
  logic           ar_hs, beat_hs;
  logic [LEN_W:0] len_ext;

  assign in_idle = (state_q == StIdle);
  assign in_data = (state_q == StData);
  assign len_ext = {1'b0, len_q};

  // On a tie the requester that did not own the last completed burst wins.
  assign pick = (S0_AXI_arvalid && S1_AXI_arvalid) ? ~last_grant_q : S1_AXI_arvalid;

  assign S0_AXI_arready = ARESETN && in_idle && S0_AXI_arvalid && !pick;
  assign S1_AXI_arready = ARESETN && in_idle && S1_AXI_arvalid && pick;
  assign ar_hs          = S0_AXI_arready || S1_AXI_arready;

  assign M_AXI_MEM_araddr  = addr_q;
  assign M_AXI_MEM_arlen   = len_q;
  assign M_AXI_MEM_arvalid = (state_q == StAddr);
  assign M_AXI_MEM_rready  = in_data && (grant_id_q ? S1_AXI_rready : S0_AXI_rready);

  assign S0_AXI_rvalid = in_data && !grant_id_q && M_AXI_MEM_rvalid;
  assign S1_AXI_rvalid = in_data && grant_id_q && M_AXI_MEM_rvalid;
  assign S0_AXI_rdata  = M_AXI_MEM_rdata;
  assign S1_AXI_rdata  = M_AXI_MEM_rdata;
  assign S0_AXI_rresp  = M_AXI_MEM_rresp;
  assign S1_AXI_rresp  = M_AXI_MEM_rresp;
  assign S0_AXI_rlast  = M_AXI_MEM_rlast;
  assign S1_AXI_rlast  = M_AXI_MEM_rlast;

  assign beat_hs  = in_data && M_AXI_MEM_rvalid && M_AXI_MEM_rready;
  assign grant_id = grant_id_q;
  assign busy     = !in_idle;
  assign len_err  = len_err_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    beat_cnt_d   = beat_cnt_q;
    len_err_d    = len_err_q;
    addr_d       = addr_q;
    len_d        = len_q;
    unique case (state_q)
      StIdle: begin
        if (ar_hs) begin
          grant_id_d = pick;
          addr_d     = pick ? S1_AXI_araddr : S0_AXI_araddr;
          len_d      = pick ? S1_AXI_arlen : S0_AXI_arlen;
          state_d    = StAddr;
        end
      end
      StAddr: begin
        if (M_AXI_MEM_arready) begin
          beat_cnt_d = '0;
          state_d    = StData;
        end
      end
      StData: begin
        if (beat_hs) begin
          if (M_AXI_MEM_rlast) begin
            if (beat_cnt_q != len_ext) len_err_d = 1'b1;
            last_grant_d = grant_id_q;
            state_d      = StIdle;
          end else begin
            // A non-last beat at or past arlen means the burst overran its length.
            if (beat_cnt_q >= len_ext) len_err_d = 1'b1;
            if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + CntOne;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!ARESETN) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      beat_cnt_q   <= '0;
      len_err_q    <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      beat_cnt_q   <= beat_cnt_d;
      len_err_q    <= len_err_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
    end
  end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Bench for mem_rd_arbiter: random requesters and memory checked every cycle against a
// transaction-level model, plus directed scenarios with hand-computed expectations.
module tb_mem_rd_arbiter;
  localparam int AW = 15;
  localparam int DW = 64;
  localparam int LW = 8;

  typedef struct {
    logic [AW-1:0] a;
    logic [LW-1:0] l;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic [AW-1:0] araddr [2];
  logic [LW-1:0] arlen  [2];
  logic          arvalid[2];
  logic          arready[2];
  logic [DW-1:0] rdata  [2];
  logic [1:0]    rresp  [2];
  logic          rlast  [2];
  logic          rvalid [2];
  logic          rready [2];
  logic [AW-1:0] m_araddr;
  logic [LW-1:0] m_arlen;
  logic          m_arvalid, m_arready;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp;
  logic          m_rlast, m_rvalid, m_rready;
  logic          grant_id, busy, len_err;

  mem_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .CLK(clk), .ARESETN(rstn),
    .S0_AXI_araddr(araddr[0]), .S0_AXI_arlen(arlen[0]), .S0_AXI_arvalid(arvalid[0]),
    .S0_AXI_arready(arready[0]), .S0_AXI_rdata(rdata[0]), .S0_AXI_rresp(rresp[0]),
    .S0_AXI_rlast(rlast[0]), .S0_AXI_rvalid(rvalid[0]), .S0_AXI_rready(rready[0]),
    .S1_AXI_araddr(araddr[1]), .S1_AXI_arlen(arlen[1]), .S1_AXI_arvalid(arvalid[1]),
    .S1_AXI_arready(arready[1]), .S1_AXI_rdata(rdata[1]), .S1_AXI_rresp(rresp[1]),
    .S1_AXI_rlast(rlast[1]), .S1_AXI_rvalid(rvalid[1]), .S1_AXI_rready(rready[1]),
    .M_AXI_MEM_araddr(m_araddr), .M_AXI_MEM_arlen(m_arlen), .M_AXI_MEM_arvalid(m_arvalid),
    .M_AXI_MEM_arready(m_arready), .M_AXI_MEM_rdata(m_rdata), .M_AXI_MEM_rresp(m_rresp),
    .M_AXI_MEM_rlast(m_rlast), .M_AXI_MEM_rvalid(m_rvalid), .M_AXI_MEM_rready(m_rready),
    .grant_id(grant_id), .busy(busy), .len_err(len_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stimulus knobs
  bit rready_rand = 0, mem_fast = 1, req_eager = 1, rand_rlast = 0;
  int override_idx = -1;
  req_t rq0[$], rq1[$];

  // Values sampled at negedge; inputs only change just after posedge
  bit ar_hs_s[2], m_ar_hs_s, m_r_hs_s, rstn_s;
  logic [LW-1:0] m_len_s;

  // Observation log
  int grant_log[$];
  int ar_cyc[2], rlast_cyc[2], beats_rx[2];
  int bursts_done = 0, m_ar_first_cyc = 0;
  bit s1_seen = 0, prev_m_arvalid = 0;
  logic [AW-1:0] m_addr_seen;
  logic [LW-1:0] m_len_seen;

  // Model: who owns the port, whether the address is still outstanding, beats seen
  bit model_ok = 0;
  int owner = -1;
  bit addr_phase, rr, mgid, merr;
  int mbeats, mlen;
  logic [AW-1:0] maddr;

  always @(negedge clk) begin
    bit free, dphase, g, e_ar0, e_ar1;
    free   = (owner < 0);
    dphase = !free && !addr_phase;
    g      = (arvalid[0] && arvalid[1]) ? !rr : arvalid[1];
    e_ar0  = rstn && free && arvalid[0] && !g;
    e_ar1  = rstn && free && arvalid[1] && g;
    if (model_ok) begin
      chk("arready0", arready[0], e_ar0);
      chk("arready1", arready[1], e_ar1);
      chk("busy", busy, !free);
      chk("m_arvalid", m_arvalid, !free && addr_phase);
      if (!free && addr_phase) begin
        chk("m_araddr", m_araddr, maddr);
        chk("m_arlen", m_arlen, mlen);
      end
      chk("m_rready", m_rready, dphase && rready[owner < 0 ? 0 : owner]);
      chk("rvalid0", rvalid[0], dphase && owner == 0 && m_rvalid);
      chk("rvalid1", rvalid[1], dphase && owner == 1 && m_rvalid);
      chk("rdata0", rdata[0], m_rdata);
      chk("rdata1", rdata[1], m_rdata);
      chk("rlast_rresp", {rlast[0], rlast[1], rresp[0], rresp[1]},
          {m_rlast, m_rlast, m_rresp, m_rresp});
      chk("grant_id", grant_id, mgid);
      chk("len_err", len_err, merr);
    end
    // Logging from observed handshakes
    for (int p = 0; p < 2; p++) begin
      ar_hs_s[p] = arvalid[p] && arready[p];
      if (ar_hs_s[p]) begin grant_log.push_back(p); ar_cyc[p] = cyc; end
      if (rvalid[p] && rready[p]) beats_rx[p]++;
    end
    if (rvalid[1]) s1_seen = 1;
    if (m_arvalid && !prev_m_arvalid) begin
      m_ar_first_cyc = cyc; m_addr_seen = m_araddr; m_len_seen = m_arlen;
    end
    prev_m_arvalid = m_arvalid;
    m_ar_hs_s = m_arvalid && m_arready;
    m_r_hs_s  = m_rvalid && m_rready;
    m_len_s   = m_arlen;
    rstn_s    = rstn;
    if (rstn && m_r_hs_s && m_rlast) begin rlast_cyc[grant_id] = cyc; bursts_done++; end
    // Model advance
    if (!rstn) begin
      owner = -1; addr_phase = 0; rr = 1; mgid = 0; merr = 0; mbeats = 0; model_ok = 1;
    end else if (free) begin
      if (e_ar0 || e_ar1) begin
        owner = e_ar1 ? 1 : 0; mgid = e_ar1; maddr = araddr[owner]; mlen = arlen[owner];
        addr_phase = 1;
      end
    end else if (addr_phase) begin
      if (m_arready) begin addr_phase = 0; mbeats = 0; end
    end else if (m_rvalid && rready[owner]) begin
      if (m_rlast) begin
        if (mbeats != mlen) merr = 1;
        rr = mgid; owner = -1;
      end else begin
        mbeats++;
        if (mbeats > mlen) merr = 1;
      end
    end
  end

  // Requester drivers: hold arvalid until accepted
  always @(posedge clk) begin
    req_t r;
    #1;
    for (int p = 0; p < 2; p++) begin
      if (ar_hs_s[p]) arvalid[p] = 0;
      if (!arvalid[p] && (req_eager || $urandom_range(0, 2) != 0)) begin
        if (p == 0 && rq0.size() > 0) begin
          r = rq0.pop_front(); araddr[0] = r.a; arlen[0] = r.l; arvalid[0] = 1;
        end else if (p == 1 && rq1.size() > 0) begin
          r = rq1.pop_front(); araddr[1] = r.a; arlen[1] = r.l; arvalid[1] = 1;
        end
      end
      rready[p] = rready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Memory responder: one burst at a time, rlast normally on beat arlen
  bit mem_active = 0;
  int beat_idx, last_idx;
  always @(posedge clk) begin
    #1;
    if (!rstn_s) begin
      mem_active = 0; m_arready = 0; m_rvalid = 0; m_rlast = 0;
    end else begin
      if (m_r_hs_s) begin
        if (m_rlast) mem_active = 0;
        else beat_idx++;
      end
      if (m_ar_hs_s) begin
        mem_active = 1; beat_idx = 0; last_idx = int'(m_len_s);
        if (override_idx >= 0) begin last_idx = override_idx; override_idx = -1; end
        else if (rand_rlast && $urandom_range(0, 7) == 0)
          last_idx = $urandom_range(0, int'(m_len_s) + 2);
      end
      m_arready = !mem_active && (mem_fast || $urandom_range(0, 1) == 1);
      if (!mem_active) m_rvalid = 0;
      else if (!m_rvalid || m_r_hs_s) begin
        m_rvalid = mem_fast || $urandom_range(0, 3) != 0;
        m_rdata  = {$urandom, $urandom};
        m_rresp  = 2'($urandom_range(0, 3));
        m_rlast  = (beat_idx == last_idx);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_req(input int p, input int a, input int l);
    req_t r;
    r.a = AW'(a); r.l = LW'(l);
    if (p == 0) rq0.push_back(r); else rq1.push_back(r);
  endtask

  task automatic do_reset();
    rstn = 0; tick(); tick(); rstn = 1;
  endtask

  // Wait for a burst count, then settle one cycle so the FSM is back in IDLE
  task automatic wait_bursts(input string name, input int target, input int budget);
    int n = 0;
    while (bursts_done < target && n < budget) begin @(negedge clk); n++; end
    if (bursts_done < target) begin
      errors++; checks++;
      $display("FAIL %s: timeout, bursts %0d expected %0d", name, bursts_done, target);
    end
    @(negedge clk);
  endtask

  initial begin
    int base;
    for (int p = 0; p < 2; p++) begin
      arvalid[p] = 0; araddr[p] = '0; arlen[p] = '0; rready[p] = 1;
    end
    m_arready = 0; m_rvalid = 0; m_rlast = 0; m_rdata = '0; m_rresp = '0;
    rstn = 0;
    repeat (3) tick();
    rstn = 1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_m_arvalid", m_arvalid, 0);

    // S0 alone, 0x0100 len 3
    beats_rx[0] = 0; s1_seen = 0; base = bursts_done;
    tick(); push_req(0, 'h100, 3);
    wait_bursts("t1", base + 1, 200);
    chk("t1_ar_latency", 64'(m_ar_first_cyc - ar_cyc[0]), 1);
    chk("t1_m_addr", m_addr_seen, 'h100);
    chk("t1_m_len", m_len_seen, 3);
    chk("t1_beats_s0", beats_rx[0], 4);
    chk("t1_s1_rvalid_seen", s1_seen, 0);
    chk("t1_len_err", len_err, 0);

    // Tie out of reset: S0 first, then S1
    do_reset(); grant_log.delete(); base = bursts_done;
    push_req(0, 'h10, 1); push_req(1, 'h20, 2);
    wait_bursts("t2", base + 2, 300);
    chk("t2_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("t2_first_grant", grant_log[0], 0);
      chk("t2_second_grant", grant_log[1], 1);
    end
    chk("t2_grant_id", grant_id, 1);

    // S1 arrives during an S0 burst; accepted one cycle after S0's rlast
    base = bursts_done; beats_rx[0] = 0;
    push_req(0, 'h40, 7);
    for (int n = 0; n < 100 && beats_rx[0] < 2; n++) @(negedge clk);
    tick(); push_req(1, 'h50, 0);
    wait_bursts("t3", base + 2, 300);
    chk("t3_s1_accept_delay", 64'(ar_cyc[1] - rlast_cyc[0]), 1);

    // Early rlast on beat index 2 for arlen 3; error sticks across a later burst
    base = bursts_done; override_idx = 2;
    push_req(0, 'h200, 3);
    wait_bursts("t4a", base + 1, 200);
    chk("t4_len_err", len_err, 1);
    chk("t4_idle", busy, 0);
    push_req(1, 'h210, 2);
    wait_bursts("t4b", base + 2, 200);
    chk("t4_len_err_sticky", len_err, 1);

    // Throttled rready on a 16-beat burst
    do_reset(); rready_rand = 1; beats_rx[0] = 0; base = bursts_done;
    push_req(0, 'h300, 15);
    wait_bursts("t5", base + 1, 400);
    chk("t5_beats_s0", beats_rx[0], 16);
    chk("t5_len_err", len_err, 0);

    // Reset pulse in the middle of a data phase
    rready_rand = 0; mem_fast = 0; beats_rx[0] = 0;
    push_req(0, 'h400, 15);
    for (int n = 0; n < 200 && beats_rx[0] < 2; n++) @(negedge clk);
    chk("t6_in_data", busy, 1);
    tick(); rstn = 0; tick(); rstn = 1;
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_valids", {arready[0], arready[1], rvalid[0], rvalid[1], m_arvalid, m_rready}, 0);

    // Random traffic
    do_reset(); rready_rand = 1; mem_fast = 0; req_eager = 0; rand_rlast = 1;
    for (int i = 0; i < 80; i++) begin
      push_req($urandom_range(0, 1), $urandom_range(0, (1 << AW) - 1), $urandom_range(0, 7));
      repeat ($urandom_range(0, 12)) tick();
    end
    for (int n = 0; n < 20000 && (rq0.size() + rq1.size() > 0 || arvalid[0] || arvalid[1]
                                  || busy); n++) @(negedge clk);
    chk("rand_drained", busy || arvalid[0] || arvalid[1], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
